// File: rtl/rv32_mc_pkg.sv
// rv32_mc_pkg
// Shared definitions for the RV32 multi-cycle control sequencer: the state
// encoding, the opcode values the sequencer recognises, and the encodings of
// the datapath mux/ALU select fields it drives.
// Optional feature macro: MC_JAL_SUPPORT_EN (adds the JAL state, the JAL opcode
// to the legal set and the memToReg=PC encoding).
package rv32_mc_pkg;

   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_EXEC_R   = 4'd2,
      ST_EXEC_I   = 4'd3,
      ST_ALU_WB   = 4'd4,
      ST_MEM_ADDR = 4'd5,
      ST_MEM_RD   = 4'd6,
      ST_MEM_WB   = 4'd7,
      ST_MEM_WR   = 4'd8,
`ifdef MC_JAL_SUPPORT_EN
      ST_BRANCH   = 4'd9,
      ST_JAL      = 4'd10
`else
      ST_BRANCH   = 4'd9
`endif
   } mc_state_e;

   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_REG   = 2'b01;
   localparam logic [1:0] SRCA_OLDPC = 2'b10;

   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;

   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_SUB    = 2'b01;
   localparam logic [1:0] ALUOP_RFUNCT = 2'b10;
   localparam logic [1:0] ALUOP_IFUNCT = 2'b11;

   localparam logic [1:0] M2R_ALUOUT = 2'b00;
   localparam logic [1:0] M2R_MDR    = 2'b01;
`ifdef MC_JAL_SUPPORT_EN
   localparam logic [1:0] M2R_PC     = 2'b10;
`endif

   // True when the sequencer has a state path for this opcode.
   function automatic logic opcode_legal(input logic [6:0] op);
      logic ok;
      ok = 1'b0;
      case (op)
         OPC_RTYPE, OPC_ITYPE, OPC_LOAD, OPC_STORE, OPC_BRANCH: ok = 1'b1;
`ifdef MC_JAL_SUPPORT_EN
         OPC_JAL: ok = 1'b1;
`endif
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mc_output_decode.sv
// mc_output_decode
// Purely combinational Moore decode of the sequencer state into the datapath
// control signals. Write enables and memRead are gated by resetn so nothing is
// written or requested while the core is held in reset.
// Ports:
//   state_i      current sequencer state
//   opcode_i     IR opcode field (only looked at in DECODE, for illegal_op)
//   mem_ready_i  memory handshake (only matters in states with a request)
//   resetn_i     active-low reset, used for output gating only
//   *_o          control outputs, same meaning as on multicycle_control
// Optional feature macro: MC_JAL_SUPPORT_EN (JAL state decode).
import rv32_mc_pkg::*;

module mc_output_decode (
   input  logic      [3:0] state_i,
   input  logic      [6:0] opcode_i,
   input  logic            mem_ready_i,
   input  logic            resetn_i,
   output logic            pc_write_o,
   output logic            pc_write_cond_o,
   output logic            ir_write_o,
   output logic            mem_read_o,
   output logic            mem_write_o,
   output logic            i_or_d_o,
   output logic            reg_write_o,
   output logic      [1:0] mem_to_reg_o,
   output logic      [1:0] alu_src_a_o,
   output logic      [1:0] alu_src_b_o,
   output logic      [1:0] alu_op_o,
   output logic            pc_source_o,
   output logic            illegal_op_o,
   output logic            instr_retired_o
);

   logic pc_write_s;
   logic pc_write_cond_s;
   logic ir_write_s;
   logic mem_read_s;
   logic mem_write_s;
   logic reg_write_s;

   // State-to-control decode; every signal defaults to 0 for unlisted states.
   always_comb begin
      pc_write_s      = 1'b0;
      pc_write_cond_s = 1'b0;
      ir_write_s      = 1'b0;
      mem_read_s      = 1'b0;
      mem_write_s     = 1'b0;
      reg_write_s     = 1'b0;
      i_or_d_o        = 1'b0;
      mem_to_reg_o    = M2R_ALUOUT;
      alu_src_a_o     = SRCA_PC;
      alu_src_b_o     = SRCB_REG;
      alu_op_o        = ALUOP_ADD;
      pc_source_o     = 1'b0;
      illegal_op_o    = 1'b0;
      instr_retired_o = 1'b0;
      case (state_i)
         ST_FETCH: begin
            mem_read_s  = 1'b1;
            alu_src_b_o = SRCB_FOUR;
            // IR and PC+4 are committed only when the instruction word arrives.
            ir_write_s  = mem_ready_i;
            pc_write_s  = mem_ready_i;
         end
         ST_DECODE: begin
            // Speculative branch/JAL target: oldPC + imm into ALUOut.
            alu_src_a_o  = SRCA_OLDPC;
            alu_src_b_o  = SRCB_IMM;
            illegal_op_o = ~opcode_legal(opcode_i);
         end
         ST_EXEC_R: begin
            alu_src_a_o = SRCA_REG;
            alu_op_o    = ALUOP_RFUNCT;
         end
         ST_EXEC_I: begin
            alu_src_a_o = SRCA_REG;
            alu_src_b_o = SRCB_IMM;
            alu_op_o    = ALUOP_IFUNCT;
         end
         ST_ALU_WB: begin
            reg_write_s     = 1'b1;
            instr_retired_o = 1'b1;
         end
         ST_MEM_ADDR: begin
            alu_src_a_o = SRCA_REG;
            alu_src_b_o = SRCB_IMM;
         end
         ST_MEM_RD: begin
            mem_read_s = 1'b1;
            i_or_d_o   = 1'b1;
         end
         ST_MEM_WB: begin
            reg_write_s     = 1'b1;
            mem_to_reg_o    = M2R_MDR;
            instr_retired_o = 1'b1;
         end
         ST_MEM_WR: begin
            mem_write_s     = 1'b1;
            i_or_d_o        = 1'b1;
            instr_retired_o = mem_ready_i;
         end
         ST_BRANCH: begin
            alu_src_a_o     = SRCA_REG;
            alu_op_o        = ALUOP_SUB;
            pc_write_cond_s = 1'b1;
            pc_source_o     = 1'b1;
            instr_retired_o = 1'b1;
         end
`ifdef MC_JAL_SUPPORT_EN
         ST_JAL: begin
            // PC already holds oldPC+4 from FETCH, so it is the link value.
            pc_write_s      = 1'b1;
            pc_source_o     = 1'b1;
            reg_write_s     = 1'b1;
            mem_to_reg_o    = M2R_PC;
            instr_retired_o = 1'b1;
         end
`endif
         default: begin
            pc_write_s = 1'b0;
         end
      endcase
   end

   // Reset gating of every write enable and the read request.
   always_comb begin
      pc_write_o      = pc_write_s      & resetn_i;
      pc_write_cond_o = pc_write_cond_s & resetn_i;
      ir_write_o      = ir_write_s      & resetn_i;
      mem_read_o      = mem_read_s      & resetn_i;
      mem_write_o     = mem_write_s     & resetn_i;
      reg_write_o     = reg_write_s     & resetn_i;
   end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
// Multi-cycle control sequencer for the RV32 core. Holds the state register,
// the opcode latched in DECODE (needed to split MEM_ADDR into load/store) and
// the retired-instruction counter; control outputs are a Moore decode of the
// state done in mc_output_decode.
// Ports:
//   clk, resetn        clock and synchronous active-low reset
//   opcode             IR[6:0], sampled in DECODE
//   mem_ready          memory completes the current request this cycle
//   pcWrite ... pcSource  datapath control
//   illegal_op         DECODE-cycle pulse on an unsupported opcode
//   instr_retired      final-cycle pulse of each instruction
//   instret            retired-instruction count (wraps)
// Optional feature macro: MC_JAL_SUPPORT_EN (JAL instruction support).
import rv32_mc_pkg::*;

module multicycle_control (
   input  logic        clk,
   input  logic        resetn,
   input  logic [6:0]  opcode,
   input  logic        mem_ready,
   output logic        pcWrite,
   output logic        pcWriteCond,
   output logic        irWrite,
   output logic        memRead,
   output logic        memWrite,
   output logic        iOrD,
   output logic        regWrite,
   output logic [1:0]  memToReg,
   output logic [1:0]  aluSrcA,
   output logic [1:0]  aluSrcB,
   output logic [1:0]  aluOp,
   output logic        pcSource,
   output logic        illegal_op,
   output logic        instr_retired,
   output logic [31:0] instret
);

   mc_state_e   state_q, state_d;
   logic [6:0]  opcode_q, opcode_d;
   logic [31:0] instret_q;
   logic [31:0] instret_d;

   assign instret_d = instret_q + {31'd0, instr_retired};
   assign instret   = instret_q;

   // Next-state selection and opcode latch.
   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      case (state_q)
         ST_FETCH: begin
            if (mem_ready) state_d = ST_DECODE;
            else           state_d = ST_FETCH;
         end
         ST_DECODE: begin
            opcode_d = opcode;
            case (opcode)
               OPC_RTYPE:           state_d = ST_EXEC_R;
               OPC_ITYPE:           state_d = ST_EXEC_I;
               OPC_LOAD, OPC_STORE: state_d = ST_MEM_ADDR;
               OPC_BRANCH:          state_d = ST_BRANCH;
`ifdef MC_JAL_SUPPORT_EN
               OPC_JAL:             state_d = ST_JAL;
`endif
               default:             state_d = ST_FETCH;
            endcase
         end
         ST_EXEC_R:   state_d = ST_ALU_WB;
         ST_EXEC_I:   state_d = ST_ALU_WB;
         ST_ALU_WB:   state_d = ST_FETCH;
         ST_MEM_ADDR: begin
            if (opcode_q == OPC_LOAD) state_d = ST_MEM_RD;
            else                      state_d = ST_MEM_WR;
         end
         ST_MEM_RD: begin
            if (mem_ready) state_d = ST_MEM_WB;
            else           state_d = ST_MEM_RD;
         end
         ST_MEM_WB:   state_d = ST_FETCH;
         ST_MEM_WR: begin
            if (mem_ready) state_d = ST_FETCH;
            else           state_d = ST_MEM_WR;
         end
         ST_BRANCH:   state_d = ST_FETCH;
`ifdef MC_JAL_SUPPORT_EN
         ST_JAL:      state_d = ST_FETCH;
`endif
         default:     state_d = ST_FETCH;
      endcase
   end

   // Sequencer state, opcode latch and retire counter; reset abandons any
   // outstanding memory request.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= ST_FETCH;
         opcode_q  <= 7'd0;
         instret_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         opcode_q  <= opcode_d;
         instret_q <= instret_d;
      end
   end

   mc_output_decode u_decode (
      .state_i         (state_q),
      .opcode_i        (opcode),
      .mem_ready_i     (mem_ready),
      .resetn_i        (resetn),
      .pc_write_o      (pcWrite),
      .pc_write_cond_o (pcWriteCond),
      .ir_write_o      (irWrite),
      .mem_read_o      (memRead),
      .mem_write_o     (memWrite),
      .i_or_d_o        (iOrD),
      .reg_write_o     (regWrite),
      .mem_to_reg_o    (memToReg),
      .alu_src_a_o     (aluSrcA),
      .alu_src_b_o     (aluSrcB),
      .alu_op_o        (aluOp),
      .pc_source_o     (pcSource),
      .illegal_op_o    (illegal_op),
      .instr_retired_o (instr_retired)
   );

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
// Directed-vector bench for multicycle_control. Each stimulus cycle pushes the
// hand-derived expected control word and instret value into a queue; a monitor
// process pops one entry per falling edge and compares against the DUT.
// Honours MC_JAL_SUPPORT_EN the same way the RTL does.
import rv32_mc_pkg::*;

module tb_multicycle_control;

   logic        clk;
   logic        resetn;
   logic [6:0]  opcode;
   logic        mem_ready;
   logic        pcWrite, pcWriteCond, irWrite, memRead, memWrite, iOrD, regWrite;
   logic [1:0]  memToReg, aluSrcA, aluSrcB, aluOp;
   logic        pcSource, illegal_op, instr_retired;
   logic [31:0] instret;

   typedef struct packed {
      logic [17:0] ctrl;
      logic [31:0] cnt;
      logic [15:0] idx;
   } exp_t;

   exp_t        sb_q[$];
   int          tests_run;
   int          tests_failed;
   logic [31:0] exp_instret;
   int          step_idx;

   multicycle_control dut (
      .clk           (clk),
      .resetn        (resetn),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .pcWrite       (pcWrite),
      .pcWriteCond   (pcWriteCond),
      .irWrite       (irWrite),
      .memRead       (memRead),
      .memWrite      (memWrite),
      .iOrD          (iOrD),
      .regWrite      (regWrite),
      .memToReg      (memToReg),
      .aluSrcA       (aluSrcA),
      .aluSrcB       (aluSrcB),
      .aluOp         (aluOp),
      .pcSource      (pcSource),
      .illegal_op    (illegal_op),
      .instr_retired (instr_retired),
      .instret       (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected control word, bit order:
   // {pcW, pcWC, irW, mRd, mWr, iOrD, regW, m2r[2], srcA[2], srcB[2], aluOp[2], pcSrc, ill, ret}
   function automatic logic [17:0] exp_ctrl(input mc_state_e st, input logic mr,
                                            input logic [6:0] op, input logic rn);
      logic pcw, pwc, irw, mrd, mw, iord, regw, pcsrc, ill, ret;
      logic [1:0] m2r, sa, sb, aop;
      pcw = 1'b0; pwc = 1'b0; irw = 1'b0; mrd = 1'b0; mw = 1'b0; iord = 1'b0;
      regw = 1'b0; pcsrc = 1'b0; ill = 1'b0; ret = 1'b0;
      m2r = 2'b00; sa = 2'b00; sb = 2'b00; aop = 2'b00;
      case (st)
         ST_FETCH:    begin mrd = 1'b1; sb = 2'b01; irw = mr; pcw = mr; end
         ST_DECODE:   begin
            sa = 2'b10; sb = 2'b10;
            ill = !(op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h23 || op == 7'h63);
`ifdef MC_JAL_SUPPORT_EN
            if (op == 7'h6F) ill = 1'b0;
`endif
         end
         ST_EXEC_R:   begin sa = 2'b01; sb = 2'b00; aop = 2'b10; end
         ST_EXEC_I:   begin sa = 2'b01; sb = 2'b10; aop = 2'b11; end
         ST_ALU_WB:   begin regw = 1'b1; ret = 1'b1; end
         ST_MEM_ADDR: begin sa = 2'b01; sb = 2'b10; end
         ST_MEM_RD:   begin mrd = 1'b1; iord = 1'b1; end
         ST_MEM_WB:   begin regw = 1'b1; m2r = 2'b01; ret = 1'b1; end
         ST_MEM_WR:   begin mw = 1'b1; iord = 1'b1; ret = mr; end
         ST_BRANCH:   begin sa = 2'b01; aop = 2'b01; pwc = 1'b1; pcsrc = 1'b1; ret = 1'b1; end
`ifdef MC_JAL_SUPPORT_EN
         ST_JAL:      begin pcw = 1'b1; pcsrc = 1'b1; regw = 1'b1; m2r = 2'b10; ret = 1'b1; end
`endif
         default:     begin ret = 1'b0; end
      endcase
      if (!rn) begin
         pcw = 1'b0; pwc = 1'b0; irw = 1'b0; regw = 1'b0; mw = 1'b0; mrd = 1'b0;
      end
      return {pcw, pwc, irw, mrd, mw, iord, regw, m2r, sa, sb, aop, pcsrc, ill, ret};
   endfunction

   // One cycle: drive inputs, queue the expected outputs for this cycle, then
   // advance to just after the next rising edge.
   task automatic step(input logic rn, input logic [6:0] op, input logic mr, input mc_state_e st);
      exp_t e;
      resetn    = rn;
      opcode    = op;
      mem_ready = mr;
      e.ctrl = exp_ctrl(st, mr, op, rn);
      e.cnt  = exp_instret;
      e.idx  = step_idx[15:0];
      sb_q.push_back(e);
      step_idx = step_idx + 1;
      if (!rn)          exp_instret = 32'd0;
      else if (e.ctrl[0]) exp_instret = exp_instret + 32'd1;
      @(posedge clk);
      #1;
   endtask

   // Monitor: one queued expectation per falling edge.
   initial begin
      exp_t e;
      logic [17:0] act;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            act = {pcWrite, pcWriteCond, irWrite, memRead, memWrite, iOrD, regWrite,
                   memToReg, aluSrcA, aluSrcB, aluOp, pcSource, illegal_op, instr_retired};
            tests_run = tests_run + 1;
            if (act !== e.ctrl) begin
               tests_failed = tests_failed + 1;
               $display("FAIL ctrl step %0d: got %05h expected %05h", e.idx, act, e.ctrl);
            end
            tests_run = tests_run + 1;
            if (instret !== e.cnt) begin
               tests_failed = tests_failed + 1;
               $display("FAIL instret step %0d: got %08h expected %08h", e.idx, instret, e.cnt);
            end
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      step_idx     = 0;
      exp_instret  = 32'd0;
      resetn       = 1'b0;
      opcode       = 7'd0;
      mem_ready    = 1'b0;
      @(posedge clk);
      #1;

      // Held in reset: FETCH decode with write enables and memRead gated.
      step(1'b0, 7'h00, 1'b1, ST_FETCH);

      // R-type, zero-wait: 4 cycles, retire in ALU_WB.
      step(1'b1, 7'h33, 1'b1, ST_FETCH);
      step(1'b1, 7'h33, 1'b1, ST_DECODE);
      step(1'b1, 7'h33, 1'b0, ST_EXEC_R);
      step(1'b1, 7'h33, 1'b1, ST_ALU_WB);

      // I-type, zero-wait.
      step(1'b1, 7'h13, 1'b1, ST_FETCH);
      step(1'b1, 7'h13, 1'b1, ST_DECODE);
      step(1'b1, 7'h13, 1'b1, ST_EXEC_I);
      step(1'b1, 7'h13, 1'b1, ST_ALU_WB);

      // Load: 2 wait cycles in FETCH, 3 in MEM_RD -> 10 cycles.
      step(1'b1, 7'h03, 1'b0, ST_FETCH);
      step(1'b1, 7'h03, 1'b0, ST_FETCH);
      step(1'b1, 7'h03, 1'b1, ST_FETCH);
      step(1'b1, 7'h03, 1'b0, ST_DECODE);
      step(1'b1, 7'h03, 1'b0, ST_MEM_ADDR);
      step(1'b1, 7'h03, 1'b0, ST_MEM_RD);
      step(1'b1, 7'h03, 1'b0, ST_MEM_RD);
      step(1'b1, 7'h03, 1'b0, ST_MEM_RD);
      step(1'b1, 7'h03, 1'b1, ST_MEM_RD);
      step(1'b1, 7'h03, 1'b1, ST_MEM_WB);

      // Store, zero-wait: retire in the single MEM_WR cycle.
      step(1'b1, 7'h23, 1'b1, ST_FETCH);
      step(1'b1, 7'h23, 1'b1, ST_DECODE);
      step(1'b1, 7'h23, 1'b1, ST_MEM_ADDR);
      step(1'b1, 7'h23, 1'b1, ST_MEM_WR);

      // Store with one write wait cycle.
      step(1'b1, 7'h23, 1'b1, ST_FETCH);
      step(1'b1, 7'h23, 1'b1, ST_DECODE);
      step(1'b1, 7'h23, 1'b1, ST_MEM_ADDR);
      step(1'b1, 7'h23, 1'b0, ST_MEM_WR);
      step(1'b1, 7'h23, 1'b1, ST_MEM_WR);

      // Branch: 3 cycles, then FETCH.
      step(1'b1, 7'h63, 1'b1, ST_FETCH);
      step(1'b1, 7'h63, 1'b1, ST_DECODE);
      step(1'b1, 7'h63, 1'b1, ST_BRANCH);

      // Illegal opcode: pulse in DECODE, back to FETCH, no retire.
      step(1'b1, 7'h7F, 1'b1, ST_FETCH);
      step(1'b1, 7'h7F, 1'b1, ST_DECODE);

      // JAL opcode: supported only with the feature macro.
      step(1'b1, 7'h6F, 1'b1, ST_FETCH);
      step(1'b1, 7'h6F, 1'b1, ST_DECODE);
`ifdef MC_JAL_SUPPORT_EN
      step(1'b1, 7'h6F, 1'b1, ST_JAL);
`endif

      // Reset while a load waits in MEM_RD.
      step(1'b1, 7'h03, 1'b1, ST_FETCH);
      step(1'b1, 7'h03, 1'b1, ST_DECODE);
      step(1'b1, 7'h03, 1'b1, ST_MEM_ADDR);
      step(1'b1, 7'h03, 1'b0, ST_MEM_RD);
      step(1'b0, 7'h03, 1'b0, ST_MEM_RD);
      step(1'b1, 7'h03, 1'b0, ST_FETCH);

      // Counter wrap: preload all-ones through the next-count net, then retire.
      force dut.instret_d = 32'hFFFF_FFFF;
      step(1'b1, 7'h33, 1'b0, ST_FETCH);
      release dut.instret_d;
      exp_instret = 32'hFFFF_FFFF;
      step(1'b1, 7'h33, 1'b1, ST_FETCH);
      step(1'b1, 7'h33, 1'b1, ST_DECODE);
      step(1'b1, 7'h33, 1'b1, ST_EXEC_R);
      step(1'b1, 7'h33, 1'b1, ST_ALU_WB);
      step(1'b1, 7'h33, 1'b0, ST_FETCH);

      // Let the monitor drain; anything left over is a failure.
      repeat (3) @(posedge clk);
      tests_run = tests_run + 1;
      if (sb_q.size() != 0) begin
         tests_failed = tests_failed + 1;
         $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
